// File: rtl/timestamp_latch_bank_if.sv
// Bus bundle for timestamp_latch_bank: event inputs, per-channel acks and the
// captured timestamp / status outputs. oMiss exists only when
// TSLB_MISS_COUNT_EN is defined.
interface timestamp_latch_bank_if #(
    parameter int pWIDTH    = 64,
    parameter int pCHANNELS = 4
);
    logic [pCHANNELS-1:0]        iLatch;
    logic [pCHANNELS-1:0]        iResetLatch;
    logic [pCHANNELS*pWIDTH-1:0] oTS;
    logic [pCHANNELS-1:0]        oRdy;
    logic [pWIDTH-1:0]           oNow;
    logic                        oWrap;
`ifdef TSLB_MISS_COUNT_EN
    logic [pCHANNELS*8-1:0]      oMiss;
`endif

    // Host / event side: drives events and acks, consumes timestamps.
    modport master (
        output iLatch,
        output iResetLatch,
        input  oTS,
        input  oRdy,
        input  oNow,
`ifdef TSLB_MISS_COUNT_EN
        input  oMiss,
`endif
        input  oWrap
    );

    // Latch bank side.
    modport slave (
        input  iLatch,
        input  iResetLatch,
        output oTS,
        output oRdy,
        output oNow,
`ifdef TSLB_MISS_COUNT_EN
        output oMiss,
`endif
        output oWrap
    );
endinterface

// File: rtl/timestamp_latch_bank.sv
// timestamp_latch_bank: one free-running timebase shared by pCHANNELS capture
// channels. Each channel synchronises its async event, captures the timebase
// (compensated for synchroniser delay) on a rising edge and holds it until
// the host acknowledges.
// Optional feature macro: TSLB_MISS_COUNT_EN adds per-channel saturating
// counts of edges dropped while a channel is busy (oMiss).
module timestamp_latch_bank #(
    parameter int pWIDTH    = 64,
    parameter int pCHANNELS = 4,
    parameter int pSYNC     = 2
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    timestamp_latch_bank_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        PEND   = 2'd2
    } state_t;

    logic [pWIDTH-1:0] now_q;
    logic [pWIDTH-1:0] now_d;
    logic              wrap_q;
    // Fills with ones after reset; top bit marks the synchroniser outputs as
    // reflecting real samples rather than reset zeros.
    logic [pSYNC-1:0]  vld_q;
    logic [pWIDTH-1:0] ts_cap;

    logic [pCHANNELS-1:0][pWIDTH-1:0] ts_all;
    logic [pCHANNELS-1:0]             rdy_all;

    always_comb begin
        now_d  = now_q + pWIDTH'(1);
        // Timebase value at the edge that first sampled the event high.
        ts_cap = now_q - pWIDTH'(pSYNC);
    end

    // Timebase, wrap pulse (registered so it lines up with the 0 reading)
    // and synchroniser-valid tracker.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            now_q  <= '0;
            wrap_q <= 1'b0;
            vld_q  <= '0;
        end else begin
            now_q  <= now_d;
            wrap_q <= &now_q;
            vld_q  <= {vld_q[pSYNC-2:0], 1'b1};
        end
    end

    assign bus.oNow  = now_q;
    assign bus.oWrap = wrap_q;
    assign bus.oTS   = ts_all;
    assign bus.oRdy  = rdy_all;

`ifdef TSLB_MISS_COUNT_EN
    logic [pCHANNELS-1:0][7:0] miss_all;
    assign bus.oMiss = miss_all;
`endif

    for (genvar g = 0; g < pCHANNELS; g++) begin : g_ch
        logic [pSYNC-1:0]  sync_q;
        logic              prev_q;
        logic              armed_q;
        state_t            state_q;
        logic [pWIDTH-1:0] ts_q;
        logic              rdy_q;
        logic              s;
        logic              rise;
        logic              ack;

        assign s    = sync_q[pSYNC-1];
        // armed_q blocks a capture for an input that was already high when
        // reset released: it must be seen low first.
        assign rise = s & ~prev_q & armed_q;
        assign ack  = bus.iResetLatch[g];

        // Synchroniser chain, edge history and re-arm tracking.
        always_ff @(posedge iCLK) begin
            if (iRST) begin
                sync_q  <= '0;
                prev_q  <= 1'b0;
                armed_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[pSYNC-2:0], bus.iLatch[g]};
                prev_q <= s;
                if (vld_q[pSYNC-1] && !s)
                    armed_q <= 1'b1;
            end
        end

        // Capture FSM; oRdy is registered alongside the state and is high
        // in every state but IDLE.
        always_ff @(posedge iCLK) begin
            if (iRST) begin
                state_q <= IDLE;
                ts_q    <= '0;
                rdy_q   <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            ts_q    <= ts_cap;
                            rdy_q   <= 1'b1;
                            state_q <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        // Ack takes priority; any edge this cycle is dropped.
                        if (ack) begin
                            if (s) begin
                                state_q <= PEND;
                            end else begin
                                state_q <= IDLE;
                                rdy_q   <= 1'b0;
                            end
                        end
                    end
                    PEND: begin
                        // Wait for the event line to drop so a held-high
                        // input cannot immediately recapture.
                        if (!s) begin
                            state_q <= IDLE;
                            rdy_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b0;
                    end
                endcase
            end
        end

        assign ts_all[g]  = ts_q;
        assign rdy_all[g] = rdy_q;

`ifdef TSLB_MISS_COUNT_EN
        logic [7:0] miss_q;

        // Saturating count of edges dropped while busy; cleared on accepted ack.
        always_ff @(posedge iCLK) begin
            if (iRST) begin
                miss_q <= '0;
            end else if (state_q == LOCKED && ack) begin
                miss_q <= '0;
            end else if (state_q != IDLE && rise && miss_q != 8'hFF) begin
                miss_q <= miss_q + 8'd1;
            end
        end

        assign miss_all[g] = miss_q;
`endif
    end

endmodule

// File: tb/tb_timestamp_latch_bank.sv
// Bench for timestamp_latch_bank: directed scenarios on a 64-bit/pSYNC=2
// instance and a randomized model comparison on an 8-bit/pSYNC=3 instance.
module tb_timestamp_latch_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    timestamp_latch_bank_if #(.pWIDTH(64), .pCHANNELS(4)) b64 ();
    timestamp_latch_bank_if #(.pWIDTH(8),  .pCHANNELS(4)) b8 ();

    timestamp_latch_bank #(.pWIDTH(64), .pCHANNELS(4), .pSYNC(2)) dut64 (
        .iCLK(clk), .iRST(rst), .bus(b64));
    timestamp_latch_bank #(.pWIDTH(8), .pCHANNELS(4), .pSYNC(3)) dut8 (
        .iCLK(clk), .iRST(rst), .bus(b8));

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        b64.iLatch = '0; b64.iResetLatch = '0;
        b8.iLatch  = '0; b8.iResetLatch  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance at negedges until the 64-bit timebase reads t (bounded).
    task automatic wait_now(input logic [63:0] t);
        int n = 0;
        while (b64.oNow !== t && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            n_cmp++; n_err++;
            $display("FAIL wait_now: timebase never reached %0d (now %0d)", t, b64.oNow);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        b64.iLatch = '0; b64.iResetLatch = '0;
        b8.iLatch  = '0; b8.iResetLatch  = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (b64.oNow !== 64'd0 || b64.oRdy !== 4'd0 || b64.oTS !== '0 || b64.oWrap !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: now=%0d rdy=%b wrap=%b, required 0/0000/0 and oTS=0",
                     b64.oNow, b64.oRdy, b64.oWrap);
        end
        rst = 1'b0;
        n_cmp++;
        if (b64.oNow !== 64'd0) begin
            n_err++;
            $display("FAIL first_cycle_now: got %0d, required 0", b64.oNow);
        end
        repeat (299) @(negedge clk);
        n_cmp++;
        if (b64.oNow !== 64'd299 || b64.oRdy !== 4'd0 || b64.oTS !== '0 || b64.oWrap !== 1'b0) begin
            n_err++;
            $display("FAIL idle_300: now=%0d rdy=%b wrap=%b, required 299/0000/0 and oTS=0",
                     b64.oNow, b64.oRdy, b64.oWrap);
        end
    endtask

    task automatic test_wrap8();
        int wraps = 0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (b8.oWrap === 1'b1) wraps++;
            if (i == 255) begin
                n_cmp++;
                if (b8.oNow !== 8'd255) begin
                    n_err++;
                    $display("FAIL wrap_pre: now=%0d, required 255", b8.oNow);
                end
            end
            if (i == 256) begin
                n_cmp++;
                if (b8.oNow !== 8'd0 || b8.oWrap !== 1'b1) begin
                    n_err++;
                    $display("FAIL wrap_at: now=%0d wrap=%b, required 0/1", b8.oNow, b8.oWrap);
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (wraps != 1) begin
            n_err++;
            $display("FAIL wrap_count: got %0d pulses, required 1", wraps);
        end
    endtask

    task automatic test_capture();
        do_reset();
        wait_now(100); b64.iLatch[1] = 1'b1;
        wait_now(102);
        n_cmp++;
        if (b64.oRdy[1] !== 1'b0) begin
            n_err++;
            $display("FAIL cap_early: rdy1=%b at now=102, required 0", b64.oRdy[1]);
        end
        @(negedge clk);
        n_cmp++;
        if (b64.oRdy[1] !== 1'b1 || b64.oTS[1*64 +: 64] !== 64'd100) begin
            n_err++;
            $display("FAIL cap_ts: rdy1=%b ts1=%0d, required 1/100", b64.oRdy[1], b64.oTS[1*64 +: 64]);
        end
        wait_now(110); b64.iLatch[1] = 1'b0;
        wait_now(115);
        b64.iResetLatch[1] = 1'b1;
        @(negedge clk);
        b64.iResetLatch[1] = 1'b0;
        n_cmp++;
        if (b64.oRdy[1] !== 1'b0 || b64.oTS[1*64 +: 64] !== 64'd100) begin
            n_err++;
            $display("FAIL cap_ack: rdy1=%b ts1=%0d, required 0/100", b64.oRdy[1], b64.oTS[1*64 +: 64]);
        end
    endtask

    task automatic test_lock_miss();
        do_reset();
        wait_now(50); b64.iLatch[0] = 1'b1;
        wait_now(60); b64.iLatch[0] = 1'b0;
        wait_now(80); b64.iLatch[0] = 1'b1;
        wait_now(84); b64.iLatch[0] = 1'b0;
        wait_now(89);
        n_cmp++;
        if (b64.oRdy[0] !== 1'b1 || b64.oTS[63:0] !== 64'd50) begin
            n_err++;
            $display("FAIL lock_hold: rdy0=%b ts0=%0d, required 1/50", b64.oRdy[0], b64.oTS[63:0]);
        end
`ifdef TSLB_MISS_COUNT_EN
        n_cmp++;
        if (b64.oMiss[7:0] !== 8'd1) begin
            n_err++;
            $display("FAIL miss_count: got %0d, required 1", b64.oMiss[7:0]);
        end
`endif
        wait_now(90);
        b64.iResetLatch[0] = 1'b1;
        @(negedge clk);
        b64.iResetLatch[0] = 1'b0;
        n_cmp++;
        if (b64.oRdy[0] !== 1'b0 || b64.oTS[63:0] !== 64'd50) begin
            n_err++;
            $display("FAIL lock_ack: rdy0=%b ts0=%0d, required 0/50", b64.oRdy[0], b64.oTS[63:0]);
        end
`ifdef TSLB_MISS_COUNT_EN
        n_cmp++;
        if (b64.oMiss[7:0] !== 8'd0) begin
            n_err++;
            $display("FAIL miss_clear: got %0d, required 0", b64.oMiss[7:0]);
        end
`endif
    endtask

    task automatic test_pend();
        do_reset();
        wait_now(20); b64.iLatch[2] = 1'b1;
        wait_now(30);
        b64.iResetLatch[2] = 1'b1;
        @(negedge clk);
        b64.iResetLatch[2] = 1'b0;
        n_cmp++;
        if (b64.oRdy[2] !== 1'b1 || b64.oTS[2*64 +: 64] !== 64'd20) begin
            n_err++;
            $display("FAIL pend_hold: rdy2=%b ts2=%0d, required 1/20", b64.oRdy[2], b64.oTS[2*64 +: 64]);
        end
        wait_now(40); b64.iLatch[2] = 1'b0;
        wait_now(42);
        n_cmp++;
        if (b64.oRdy[2] !== 1'b1) begin
            n_err++;
            $display("FAIL pend_late: rdy2=%b at now=42, required 1", b64.oRdy[2]);
        end
        @(negedge clk);
        n_cmp++;
        if (b64.oRdy[2] !== 1'b0) begin
            n_err++;
            $display("FAIL pend_release: rdy2=%b at now=43, required 0", b64.oRdy[2]);
        end
        wait_now(50);
        n_cmp++;
        if (b64.oRdy !== 4'b0000 || b64.oTS[2*64 +: 64] !== 64'd20) begin
            n_err++;
            $display("FAIL pend_norecap: rdy=%b ts2=%0d, required 0000/20", b64.oRdy, b64.oTS[2*64 +: 64]);
        end
    endtask

    task automatic test_simul_rst();
        do_reset();
        wait_now(500); b64.iLatch = 4'b1001;
        wait_now(503);
        n_cmp++;
        if (b64.oRdy !== 4'b1001 || b64.oTS[63:0] !== 64'd500 || b64.oTS[3*64 +: 64] !== 64'd500
            || b64.oTS[1*64 +: 64] !== 64'd0) begin
            n_err++;
            $display("FAIL simul_cap: rdy=%b ts0=%0d ts3=%0d ts1=%0d, required 1001/500/500/0",
                     b64.oRdy, b64.oTS[63:0], b64.oTS[3*64 +: 64], b64.oTS[1*64 +: 64]);
        end
        wait_now(510);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b64.oRdy !== 4'b0000 || b64.oTS !== '0 || b64.oNow !== 64'd0) begin
            n_err++;
            $display("FAIL mid_reset: rdy=%b now=%0d, required 0000/0 and oTS=0", b64.oRdy, b64.oNow);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (b64.oRdy !== 4'b0000) begin
            n_err++;
            $display("FAIL high_at_release: rdy=%b, required 0000", b64.oRdy);
        end
        wait_now(20); b64.iLatch = 4'b0000;
        wait_now(25); b64.iLatch[3] = 1'b1;
        wait_now(28);
        n_cmp++;
        if (b64.oRdy !== 4'b1000 || b64.oTS[3*64 +: 64] !== 64'd25) begin
            n_err++;
            $display("FAIL rearm: rdy=%b ts3=%0d, required 1000/25", b64.oRdy, b64.oTS[3*64 +: 64]);
        end
        b64.iLatch = 4'b0000;
    endtask

    // Reference model: each channel captures the time its input was first
    // sampled high (a low->high pair of samples), noticed pSYNC cycles later.
    task automatic test_random();
        localparam int SY = 3;
        logic [3:0] samp[$];
        int         st[4];      // 0 idle, 1 locked, 2 pending
        logic [7:0] mts[4];
        int         mmiss[4];
        logic [3:0] lat = 4'd0;
        logic [3:0] ack;
        logic [3:0] exp_rdy;
        logic [31:0] exp_ts;
        logic [31:0] exp_miss;
        logic       exp_wrap;
        logic       bad;
        int         k;
        logic       hi_k, rise_k;
        for (int ch = 0; ch < 4; ch++) begin st[ch] = 0; mts[ch] = 8'd0; mmiss[ch] = 0; end
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int ch = 0; ch < 4; ch++) begin
                exp_rdy[ch] = (st[ch] != 0);
                exp_ts[ch*8 +: 8] = mts[ch];
                exp_miss[ch*8 +: 8] = 8'(mmiss[ch]);
            end
            exp_wrap = (c > 0) && (c % 256 == 0);
            bad = (b8.oNow !== 8'(c)) || (b8.oWrap !== exp_wrap) || (b8.oRdy !== exp_rdy) || (b8.oTS !== exp_ts);
`ifdef TSLB_MISS_COUNT_EN
            if (b8.oMiss !== exp_miss) bad = 1'b1;
`endif
            n_cmp++;
            if (bad) begin
                n_err++;
                $display("FAIL rand cyc=%0d now=%0d/%0d wrap=%b/%b rdy=%b/%b ts=%h/%h",
                         c, b8.oNow, 8'(c), b8.oWrap, exp_wrap, b8.oRdy, exp_rdy, b8.oTS, exp_ts);
            end
            for (int ch = 0; ch < 4; ch++) begin
                if ($urandom_range(0, 9) == 0) lat[ch] = ~lat[ch];
                ack[ch] = ($urandom_range(0, 5) == 0);
            end
            b8.iLatch = lat;
            b8.iResetLatch = ack;
            samp.push_back(lat);
            k = c - SY;
            for (int ch = 0; ch < 4; ch++) begin
                hi_k   = (k >= 0) && samp[k][ch];
                rise_k = (k >= 1) && hi_k && !samp[k-1][ch];
                if (st[ch] == 0) begin
                    if (rise_k) begin st[ch] = 1; mts[ch] = 8'(k); end
                end else if (st[ch] == 1) begin
                    if (ack[ch]) begin
                        st[ch] = hi_k ? 2 : 0;
                        mmiss[ch] = 0;
                    end else if (rise_k && mmiss[ch] < 255) begin
                        mmiss[ch]++;
                    end
                end else begin
                    if (rise_k && mmiss[ch] < 255) mmiss[ch]++;
                    if (!hi_k) st[ch] = 0;
                end
            end
            @(negedge clk);
        end
        b8.iLatch = '0;
        b8.iResetLatch = '0;
    endtask

    initial begin
        b64.iLatch = '0; b64.iResetLatch = '0;
        b8.iLatch  = '0; b8.iResetLatch  = '0;
        test_reset();
        test_wrap8();
        test_capture();
        test_lock_miss();
        test_pend();
        test_simul_rst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
